// File: rtl/vend_pkg.sv
// Shared constants and helpers for the multi-product vending controller.
package vend_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CREDIT = 2'd1;
  localparam logic [1:0] ST_VEND   = 2'd2;
  localparam logic [1:0] ST_CHANGE = 2'd3;

  localparam int unsigned COIN_UNIT   = 1;
  localparam int unsigned PRICE_BUS_W = 256;
  localparam int unsigned PRICE_W_MAX = 32;

  // Pull the price of item idx out of a packed price table of width-bit entries.
  function automatic logic [PRICE_W_MAX-1:0] price_extract(input logic [PRICE_BUS_W-1:0] prices,
                                                           input int unsigned idx,
                                                           input int unsigned width);
    logic [PRICE_BUS_W-1:0] shifted;
    logic [PRICE_W_MAX-1:0] mask;
    shifted = prices >> (idx * width);
    mask    = PRICE_W_MAX'((64'd1 << width) - 64'd1);
    return PRICE_W_MAX'(shifted) & mask;
  endfunction

endpackage

// File: rtl/vend_ctrl_multi_if.sv
// Coin-acceptor / dispenser / change-hopper bundle for the vending controller.
interface vend_ctrl_multi_if #(
  parameter int unsigned CREDIT_W  = 8,
  parameter int unsigned COIN_W    = 3,
  parameter int unsigned NUM_ITEMS = 4
);
  localparam int unsigned ITEM_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;

  logic                 coin_valid;
  logic [COIN_W-1:0]    coin_val;
  logic                 cancel;
  logic                 sel_valid;
  logic [ITEM_W-1:0]    sel_item;
  logic [NUM_ITEMS-1:0] item_empty;
  logic                 dispense;
  logic [ITEM_W-1:0]    dispense_item;
  logic                 coin_reject;
  logic                 sel_nack;
  logic                 change_valid;
  logic                 change_ready;
  logic [CREDIT_W-1:0]  credit;
  logic                 busy;

  modport master (
    output coin_valid, coin_val, cancel, sel_valid, sel_item, item_empty, change_ready,
    input  dispense, dispense_item, coin_reject, sel_nack, change_valid, credit, busy
  );

  modport slave (
    input  coin_valid, coin_val, cancel, sel_valid, sel_item, item_empty, change_ready,
    output dispense, dispense_item, coin_reject, sel_nack, change_valid, credit, busy
  );
endinterface

// File: rtl/vend_change_out.sv
// Credit register that either loads a new value or pays itself out one unit per valid/ready beat.
module vend_change_out
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                drain,
  input  logic [CREDIT_W-1:0] load_val,
  input  logic                change_ready,
  output logic [CREDIT_W-1:0] credit,
  output logic                change_valid,
  output logic                last_beat_c
);

  always_ff @(posedge clk) begin
    if (reset) begin
      credit       <= '0;
      change_valid <= 1'b0;
    end else if (load) begin
      credit       <= load_val;
      change_valid <= drain && (load_val != '0);
    end else if (change_valid && change_ready) begin
      credit       <= credit - CREDIT_W'(COIN_UNIT);
      change_valid <= (credit != CREDIT_W'(COIN_UNIT));
    end
  end

  assign last_beat_c = change_valid && change_ready && (credit == CREDIT_W'(COIN_UNIT));

endmodule

// File: rtl/vend_ctrl_multi.sv
// Multi-product vending controller: credit accumulation, priced vend, unit-wise change and refund.
module vend_ctrl_multi
  import vend_pkg::*;
#(
  parameter int unsigned                   CREDIT_W   = 8,
  parameter int unsigned                   COIN_W     = 3,
  parameter int unsigned                   NUM_ITEMS  = 4,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES     = {8'd6, 8'd5, 8'd4, 8'd3},
  parameter logic [CREDIT_W-1:0]           MAX_CREDIT = 8'd40,
  parameter int unsigned                   TIMEOUT    = 1000
) (
  input logic             clk,
  input logic             reset,
  vend_ctrl_multi_if.slave bus
);

  localparam int unsigned ITEM_W  = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
  localparam int unsigned TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned SUM_W   = CREDIT_W + 1;

  logic [1:0]          state, state_nxt;
  logic [TIMER_W-1:0]  timer, timer_nxt;
  logic [CREDIT_W-1:0] credit, credit_nxt, price;
  logic [COIN_W-1:0]   coin_val;
  logic [SUM_W-1:0]    coin_sum;
  logic                coin_ok, sel_ok, coin_acc, load, drain, last_beat_c, change_valid;
  logic                dispense, dispense_nxt, coin_reject, sel_nack, sel_nack_nxt, busy;
  logic [ITEM_W-1:0]   dispense_item, item_nxt;

  assign coin_val = bus.coin_val;
  assign price    = CREDIT_W'(price_extract(PRICE_BUS_W'(PRICES), 32'(bus.sel_item), CREDIT_W));
  assign coin_sum = SUM_W'(credit) + SUM_W'(coin_val);
  assign coin_ok  = (coin_val != '0) && (coin_sum <= SUM_W'(MAX_CREDIT));
  assign sel_ok   = (32'(bus.sel_item) < NUM_ITEMS) && !bus.item_empty[bus.sel_item]
                    && (SUM_W'(credit) >= SUM_W'(price));

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      timer         <= '0;
      dispense      <= 1'b0;
      dispense_item <= '0;
      coin_reject   <= 1'b0;
      sel_nack      <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nxt;
      timer         <= timer_nxt;
      dispense      <= dispense_nxt;
      dispense_item <= item_nxt;
      coin_reject   <= bus.coin_valid && !coin_acc;
      sel_nack      <= sel_nack_nxt;
      busy          <= (state_nxt == ST_VEND) || (state_nxt == ST_CHANGE);
    end
  end

  // Event arbitration: cancel > selection > coin; CHANGE hands credit to the payout counter.
  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer;
    credit_nxt   = credit;
    load         = 1'b0;
    coin_acc     = 1'b0;
    dispense_nxt = 1'b0;
    item_nxt     = '0;
    sel_nack_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        load = 1'b1;
        if (bus.sel_valid) begin
          sel_nack_nxt = 1'b1;
        end else if (bus.coin_valid && coin_ok) begin
          coin_acc   = 1'b1;
          credit_nxt = CREDIT_W'(coin_sum);
          timer_nxt  = '0;
          state_nxt  = ST_CREDIT;
        end
      end
      ST_CREDIT: begin
        load = 1'b1;
        if (bus.cancel) begin
          timer_nxt = '0;
          state_nxt = ST_CHANGE;
        end else if (bus.sel_valid) begin
          timer_nxt = '0;
          if (sel_ok) begin
            credit_nxt   = credit - price;
            dispense_nxt = 1'b1;
            item_nxt     = bus.sel_item;
            state_nxt    = ST_VEND;
          end else begin
            sel_nack_nxt = 1'b1;
          end
        end else if (bus.coin_valid && coin_ok) begin
          coin_acc   = 1'b1;
          credit_nxt = CREDIT_W'(coin_sum);
          timer_nxt  = '0;
        end else if (timer == TIMER_W'(TIMEOUT - 1)) begin
          timer_nxt = '0;
          state_nxt = ST_CHANGE;
        end else begin
          timer_nxt = timer + TIMER_W'(1);
        end
      end
      ST_VEND: begin
        load      = 1'b1;
        state_nxt = (credit != '0) ? ST_CHANGE : ST_IDLE;
      end
      ST_CHANGE: begin
        if ((credit == '0) || last_beat_c) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    drain = (state_nxt == ST_CHANGE);
  end

  vend_change_out #(.CREDIT_W(CREDIT_W)) u_change (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .drain        (drain),
    .load_val     (credit_nxt),
    .change_ready (bus.change_ready),
    .credit       (credit),
    .change_valid (change_valid),
    .last_beat_c  (last_beat_c)
  );

  assign bus.credit        = credit;
  assign bus.change_valid  = change_valid;
  assign bus.dispense      = dispense;
  assign bus.dispense_item = dispense_item;
  assign bus.coin_reject   = coin_reject;
  assign bus.sel_nack      = sel_nack;
  assign bus.busy          = busy;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Directed scenarios plus randomized traffic checked cycle-by-cycle against a behavioural vending model.
module tb_vend_ctrl_multi;

  localparam int unsigned CREDIT_W  = 8;
  localparam int unsigned COIN_W    = 3;
  localparam int unsigned NUM_ITEMS = 4;
  localparam int unsigned TO        = 64;
  localparam int          MAXC      = 40;
  localparam logic [31:0] PRICES    = {8'd6, 8'd5, 8'd4, 8'd3};

  localparam int M_IDLE = 0, M_CREDIT = 1, M_VEND = 2, M_CHANGE = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vend_ctrl_multi_if #(.CREDIT_W(CREDIT_W), .COIN_W(COIN_W), .NUM_ITEMS(NUM_ITEMS)) bus ();

  vend_ctrl_multi #(
    .CREDIT_W(CREDIT_W), .COIN_W(COIN_W), .NUM_ITEMS(NUM_ITEMS),
    .PRICES(PRICES), .MAX_CREDIT(8'd40), .TIMEOUT(TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int price_tbl[NUM_ITEMS] = '{3, 4, 5, 6};

  int m_st = M_IDLE, m_credit = 0, m_idle = 0;
  int e_disp = 0, e_item = 0, e_rej = 0, e_nack = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic quiet_inputs();
    bus.coin_valid = 1'b0;
    bus.coin_val   = '0;
    bus.cancel     = 1'b0;
    bus.sel_valid  = 1'b0;
    bus.sel_item   = '0;
  endtask

  // Advance one clock: update the model from the inputs, then compare every output.
  task automatic step();
    int ci, si;
    bit acc;
    ci = int'(bus.coin_val);
    si = int'(bus.sel_item);
    acc = 0;
    e_disp = 0; e_item = 0; e_nack = 0;
    case (m_st)
      M_IDLE: begin
        if (bus.sel_valid) e_nack = 1;
        else if (bus.coin_valid && ci != 0 && m_credit + ci <= MAXC) begin
          m_credit += ci; m_idle = 0; m_st = M_CREDIT; acc = 1;
        end
      end
      M_CREDIT: begin
        if (bus.cancel) begin
          m_st = M_CHANGE; m_idle = 0;
        end else if (bus.sel_valid) begin
          m_idle = 0;
          if (!bus.item_empty[si] && m_credit >= price_tbl[si]) begin
            m_credit -= price_tbl[si]; m_st = M_VEND; e_disp = 1; e_item = si;
          end else e_nack = 1;
        end else if (bus.coin_valid && ci != 0 && m_credit + ci <= MAXC) begin
          m_credit += ci; m_idle = 0; acc = 1;
        end else if (m_idle == TO - 1) begin
          m_st = M_CHANGE; m_idle = 0;
        end else m_idle++;
      end
      M_VEND: m_st = (m_credit > 0) ? M_CHANGE : M_IDLE;
      default: begin
        if (m_credit > 0 && bus.change_ready) m_credit--;
        if (m_credit == 0) m_st = M_IDLE;
      end
    endcase
    e_rej = (bus.coin_valid && !acc) ? 1 : 0;
    @(posedge clk);
    #1;
    if (reset) begin
      m_st = M_IDLE; m_credit = 0; m_idle = 0;
      e_disp = 0; e_item = 0; e_rej = 0; e_nack = 0;
    end
    check("credit", int'(bus.credit), m_credit);
    check("change_valid", int'(bus.change_valid), (m_st == M_CHANGE && m_credit > 0) ? 1 : 0);
    check("busy", int'(bus.busy), (m_st == M_VEND || m_st == M_CHANGE) ? 1 : 0);
    check("dispense", int'(bus.dispense), e_disp);
    check("dispense_item", int'(bus.dispense_item), e_item);
    check("coin_reject", int'(bus.coin_reject), e_rej);
    check("sel_nack", int'(bus.sel_nack), e_nack);
  endtask

  task automatic coin(input int v);
    bus.coin_valid = 1'b1;
    bus.coin_val   = COIN_W'(v);
    step();
    quiet_inputs();
  endtask

  task automatic select(input int item);
    bus.sel_valid = 1'b1;
    bus.sel_item  = 2'(item);
    step();
    quiet_inputs();
  endtask

  // Pay out change until the controller leaves CHANGE; beats are counted from the DUT handshake.
  task automatic drain(input string tag, input int budget, input bit rand_ready, input int exp_beats);
    int beats;
    beats = 0;
    for (int i = 0; i < budget && bus.busy; i++) begin
      bus.change_ready = rand_ready ? 1'($urandom % 2) : 1'b1;
      if (bus.change_valid && bus.change_ready) beats++;
      step();
    end
    bus.change_ready = 1'b0;
    check({tag, " left CHANGE"}, int'(bus.busy), 0);
    check({tag, " beats"}, beats, exp_beats);
  endtask

  initial begin
    int first_busy;
    int quiet;
    reset = 1'b1;
    quiet_inputs();
    bus.item_empty   = '0;
    bus.change_ready = 1'b0;
    step();
    step();
    check("reset credit", int'(bus.credit), 0);
    check("reset busy", int'(bus.busy), 0);
    reset = 1'b0;

    // 1: exact change after a vend
    bus.change_ready = 1'b1;
    coin(2);
    coin(2);
    select(0);
    check("t1 dispense", int'(bus.dispense), 1);
    check("t1 item", int'(bus.dispense_item), 0);
    check("t1 credit after vend", int'(bus.credit), 1);
    drain("t1", 10, 1'b0, 1);
    check("t1 credit end", int'(bus.credit), 0);

    // 2: short credit, then top up and vend with no change
    coin(5);
    select(3);
    check("t2 nack", int'(bus.sel_nack), 1);
    check("t2 credit", int'(bus.credit), 5);
    coin(1);
    select(3);
    check("t2 dispense", int'(bus.dispense), 1);
    check("t2 item", int'(bus.dispense_item), 3);
    step();
    check("t2 no change", int'(bus.change_valid), 0);
    check("t2 idle", int'(bus.busy), 0);

    // 3: ceiling reject then full refund with a stuttering hopper
    for (int i = 0; i < 5; i++) coin(7);
    coin(3);
    coin(4);
    check("t3 reject", int'(bus.coin_reject), 1);
    check("t3 credit", int'(bus.credit), 38);
    bus.cancel = 1'b1;
    step();
    quiet_inputs();
    drain("t3", 400, 1'b1, 38);

    // 4: inactivity timeout
    coin(3);
    first_busy = -1;
    for (int k = 1; k <= TO + 2; k++) begin
      step();
      if (bus.busy && first_busy < 0) first_busy = k;
    end
    check("t4 timeout cycle", first_busy, TO);
    drain("t4", 20, 1'b0, 3);

    // 5: cancel outranks selection and coin
    coin(5);
    bus.cancel = 1'b1; bus.sel_valid = 1'b1; bus.sel_item = 2'd0;
    bus.coin_valid = 1'b1; bus.coin_val = 3'd1;
    step();
    quiet_inputs();
    check("t5 reject", int'(bus.coin_reject), 1);
    check("t5 no dispense", int'(bus.dispense), 0);
    check("t5 refund", int'(bus.change_valid), 1);
    drain("t5", 20, 1'b0, 5);

    // 6: sold-out item, then reset while paying out
    bus.item_empty = 4'b0010;
    coin(7);
    select(1);
    check("t6 nack", int'(bus.sel_nack), 1);
    bus.cancel = 1'b1;
    step();
    quiet_inputs();
    step();
    check("t6 stalled", int'(bus.change_valid), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6 reset credit", int'(bus.credit), 0);
    check("t6 reset valid", int'(bus.change_valid), 0);
    check("t6 reset busy", int'(bus.busy), 0);
    bus.item_empty = '0;

    // Randomized traffic with occasional quiet stretches to reach the timeout
    quiet = 0;
    for (int n = 0; n < 3000; n++) begin
      quiet_inputs();
      if (quiet > 0) quiet--;
      else if ($urandom % 150 == 0) quiet = TO + 5;
      if (quiet == 0) begin
        bus.coin_valid = 1'($urandom % 3 == 0);
        bus.coin_val   = 3'($urandom);
        bus.sel_valid  = 1'($urandom % 7 == 0);
        bus.sel_item   = 2'($urandom);
        bus.cancel     = (m_st == M_CREDIT) ? 1'($urandom % 20 == 0) : 1'b0;
      end
      if ($urandom % 40 == 0) bus.item_empty = 4'($urandom) & 4'($urandom);
      bus.change_ready = 1'($urandom % 2);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
